// File: rtl/ifu_fetch_queue_if.sv
// Fetch-unit bus bundle: I-cache request/response and ID-stage handshake.
interface ifu_fetch_queue_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            cache_valid;
  logic            cache_ready;
  logic [XLEN-1:0] cache_addr;
  logic            cache_data_ok;
  logic [XLEN-1:0] cache_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_inst;

  // Fetch unit side: issues cache requests, presents queue head to ID.
  modport master (
    output cache_valid, cache_addr, id_valid, id_pc, id_inst,
    input  cache_ready, cache_data_ok, cache_data, id_ready
  );

  // Cache / ID side.
  modport slave (
    input  cache_valid, cache_addr, id_valid, id_pc, id_inst,
    output cache_ready, cache_data_ok, cache_data, id_ready
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, keeps one I-cache request in
// flight and decouples the ID stage through a DEPTH-entry {pc,inst} queue.
module ifu_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter bit              WORD_SEL = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  ifu_fetch_queue_if.master          bus,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [ILEN-1:0] inst_q [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fire, push, pop;
  logic [XLEN-1:0] data_sh;

  // Request only from IDLE with room; redirect suppresses issue that cycle.
  assign bus.cache_valid = (state == IDLE) && !reset && !redirect_valid &&
                           (count < CW'(DEPTH));
  assign bus.cache_addr  = fetch_pc;
  assign fire = bus.cache_valid && bus.cache_ready;
  // A redirect kills a response arriving in the same cycle.
  assign push = (state == WAIT) && bus.cache_data_ok && !redirect_valid;
  assign pop  = bus.id_valid && bus.id_ready;

  // Pick the 32-bit word addressed by pc[2] out of the 64-bit line.
  assign data_sh = (WORD_SEL && req_pc[2]) ? (bus.cache_data >> ILEN) : bus.cache_data;

  assign bus.id_valid = (count != '0);
  assign bus.id_pc    = pc_q[rd_ptr];
  assign bus.id_inst  = inst_q[rd_ptr];
  assign q_count      = count;

  // FSM next state; redirect while waiting converts the wait into a drop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire) state_nxt = WAIT;
      WAIT:    if (bus.cache_data_ok) state_nxt = IDLE;
               else if (redirect_valid) state_nxt = DROP;
      DROP:    if (bus.cache_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Fetch PC and request PC tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (fire) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Queue storage and pointers; redirect empties the queue next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]   <= req_pc;
        inst_q[wr_ptr] <= data_sh[ILEN-1:0];
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: inputs driven and outputs sampled on
// the falling clock edge, expected values hand-computed.
module tb_ifu_fetch_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [2:0]  q_count;
  int          checks = 0;
  int          errors = 0;

  ifu_fetch_queue_if bus ();

  ifu_fetch_queue dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master),
    .q_count        (q_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Cache line for address a: low word a+0x20000000, high word a+0x10000000.
  function automatic logic [63:0] line(input logic [63:0] a);
    return {a[31:0] + 32'h1000_0000, a[31:0] + 32'h2000_0000};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    bus.cache_ready = 1'b0; bus.cache_data_ok = 1'b0; bus.cache_data = '0;
    bus.id_ready = 1'b0;
    @(negedge clock);
    chk("rst_cache_valid", 64'(bus.cache_valid), 64'd0);
    @(negedge clock);
    chk("rst_q_count", 64'(q_count), 64'd0);
    chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
    reset = 1'b0;
    #1;
  endtask

  // One request/response: accept in phase A, data_ok in phase B.
  task automatic serve(input logic [63:0] addr, input logic rdy_a, input logic rdy_b);
    bus.id_ready = rdy_a;
    bus.cache_data_ok = 1'b0;
    #1;
    chk("req_valid", 64'(bus.cache_valid), 64'd1);
    chk("req_addr", bus.cache_addr, addr);
    @(negedge clock);
    chk("wait_no_req", 64'(bus.cache_valid), 64'd0);
    bus.id_ready = rdy_b;
    bus.cache_data_ok = 1'b1;
    bus.cache_data = line(addr);
    @(negedge clock);
    bus.cache_data_ok = 1'b0;
  endtask

  logic [31:0] exp_inst [4] = '{32'hA000_0000, 32'h9000_0004, 32'hA000_0008, 32'h9000_000C};

  initial begin
    // 1: streaming fetch, ID always ready
    do_reset();
    bus.cache_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve(64'h8000_0000 + 64'(4 * k), 1'b1, 1'b1);
      chk("t1_id_valid", 64'(bus.id_valid), 64'd1);
      chk("t1_id_pc", bus.id_pc, 64'h8000_0000 + 64'(4 * k));
      chk("t1_id_inst", 64'(bus.id_inst), 64'(exp_inst[k]));
      chk("t1_q_count", 64'(q_count), 64'd1);
    end

    // 2: ID stalled -> queue fills to 4, issue stops; then in-order drain
    do_reset();
    bus.cache_ready = 1'b1;
    for (int k = 0; k < 4; k++) serve(64'h8000_0000 + 64'(4 * k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("t2_full_no_req", 64'(bus.cache_valid), 64'd0);
      chk("t2_full_count", 64'(q_count), 64'd4);
      @(negedge clock);
    end
    bus.cache_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain_pc", bus.id_pc, 64'h8000_0000 + 64'(4 * k));
      chk("t2_drain_inst", 64'(bus.id_inst), 64'(exp_inst[k]));
      bus.id_ready = 1'b1;
      @(negedge clock);
    end
    chk("t2_empty_count", 64'(q_count), 64'd0);
    chk("t2_empty_valid", 64'(bus.id_valid), 64'd0);
    chk("t2_resume_valid", 64'(bus.cache_valid), 64'd1);
    chk("t2_resume_addr", bus.cache_addr, 64'h8000_0010);

    // 3: redirect while waiting; stale response 3 cycles later discarded
    do_reset();
    bus.cache_ready = 1'b1;
    @(negedge clock);
    bus.cache_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    @(negedge clock);
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("t3_drop_no_req", 64'(bus.cache_valid), 64'd0);
      @(negedge clock);
    end
    chk("t3_drop_no_req", 64'(bus.cache_valid), 64'd0);
    bus.cache_data_ok = 1'b1; bus.cache_data = line(64'h8000_0000);
    @(negedge clock);
    bus.cache_data_ok = 1'b0;
    chk("t3_count", 64'(q_count), 64'd0);
    chk("t3_id_valid", 64'(bus.id_valid), 64'd0);
    chk("t3_req_valid", 64'(bus.cache_valid), 64'd1);
    chk("t3_req_addr", bus.cache_addr, 64'h8000_1000);

    // 4a: redirect coincident with data_ok drops the response
    do_reset();
    bus.cache_ready = 1'b1;
    @(negedge clock);
    bus.cache_data_ok = 1'b1; bus.cache_data = line(64'h8000_0000);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    @(negedge clock);
    bus.cache_data_ok = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("t4a_count", 64'(q_count), 64'd0);
    chk("t4a_id_valid", 64'(bus.id_valid), 64'd0);
    chk("t4a_req_valid", 64'(bus.cache_valid), 64'd1);
    chk("t4a_req_addr", bus.cache_addr, 64'h8000_2000);
    // 4b: redirect in IDLE with cache_ready high -> no handshake
    redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    #1;
    chk("t4b_suppressed", 64'(bus.cache_valid), 64'd0);
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    chk("t4b_still_idle", 64'(bus.cache_valid), 64'd1);
    chk("t4b_addr", bus.cache_addr, 64'h8000_3000);

    // 5: queue at 3, push+pop same cycle keeps count; order across wrap
    do_reset();
    bus.cache_ready = 1'b1;
    for (int k = 0; k < 3; k++) serve(64'h8000_0000 + 64'(4 * k), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t5_count", 64'(q_count), 64'd3);
      chk("t5_head_pc", bus.id_pc, 64'h8000_0000 + 64'(4 * k));
      serve(64'h8000_000C + 64'(4 * k), 1'b0, 1'b1);
    end
    chk("t5_count_end", 64'(q_count), 64'd3);
    bus.cache_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_drain_pc", bus.id_pc, 64'h8000_0010 + 64'(4 * k));
      bus.id_ready = 1'b1;
      @(negedge clock);
    end
    chk("t5_empty", 64'(q_count), 64'd0);

    // 6: reset during WAIT; later data_ok ignored in IDLE
    do_reset();
    bus.cache_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rst_no_req", 64'(bus.cache_valid), 64'd0);
    chk("t6_rst_count", 64'(q_count), 64'd0);
    reset = 1'b0; bus.cache_ready = 1'b0;
    #1;
    chk("t6_pc", bus.cache_addr, 64'h8000_0000);
    bus.cache_data_ok = 1'b1; bus.cache_data = line(64'h8000_0000);
    @(negedge clock);
    bus.cache_data_ok = 1'b0;
    chk("t6_ignored_count", 64'(q_count), 64'd0);
    chk("t6_ignored_valid", 64'(bus.id_valid), 64'd0);
    chk("t6_req_valid", 64'(bus.cache_valid), 64'd1);
    chk("t6_req_addr", bus.cache_addr, 64'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
